layer_1_pixel_sequencer: RTL and testbench

- Upstream control stage for the layer-1 5-neuron mask-multiply/accumulate block.
- Captures one 16x16 binary Semeion image (256 mask bits) and walks it one pixel per cycle.
- Reads the five 8-bit layer-1 weights for each pixel from a synchronous weight ROM.
- Drives the accumulator block's clear, load, accumulate, mask and five vector inputs, then reports done once all five sums are final.

---
 rtl/layer_1_pixel_sequencer_pkg.sv | 26 ++
 rtl/layer_1_pixel_sequencer_image_shift_register.sv | 36 +++
 rtl/layer_1_pixel_sequencer.sv | 167 ++++++++++++++++
 tb/tb_layer_1_pixel_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_1_pixel_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the layer-1 pixel sequencer.
package layer_1_pixel_sequencer_pkg;

  localparam int unsigned SIZE            = 8;
  localparam int unsigned NUM_NEURONS     = 5;
  localparam int unsigned NUM_PIXELS      = 256;
  localparam int unsigned ADDR_WIDTH      = $clog2(NUM_PIXELS);
  // Matches the downstream load-register + accumulate-register pipeline depth.
  localparam int unsigned DRAIN_CYCLES    = 2;
  localparam int unsigned DRAIN_CNT_WIDTH = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StStream = 3'd2,
    StDrain  = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Extract the weight lane of neuron n (0-based); neuron 1 sits in the low bits.
  function automatic logic [SIZE-1:0] weight_lane(input logic [NUM_NEURONS*SIZE-1:0] word,
                                                  input int unsigned n);
    return word[n*SIZE +: SIZE];
  endfunction

endpackage

// File: rtl/layer_1_pixel_sequencer_image_shift_register.sv
// Holds the captured image and presents pixels in order, one per shift.
module layer_1_pixel_sequencer_image_shift_register
  import layer_1_pixel_sequencer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [NUM_PIXELS-1:0] data_i,
  output logic                  pixel_o
);

  logic [NUM_PIXELS-1:0] img_q, img_d;

  // Load wins over shift; bit 0 is always the next pixel to issue.
  always_comb begin
    img_d = img_q;
    if (load_i) begin
      img_d = data_i;
    end else if (shift_i) begin
      img_d = {1'b0, img_q[NUM_PIXELS-1:1]};
    end
  end

  // Image storage register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      img_q <= '0;
    end else begin
      img_q <= img_d;
    end
  end

  assign pixel_o = img_q[0];

endmodule

// File: rtl/layer_1_pixel_sequencer.sv
// Walks a captured 16x16 binary image one pixel per cycle, fetching the five
// layer-1 weights per pixel from a synchronous ROM and driving the downstream
// mask-multiply/accumulate block.
module layer_1_pixel_sequencer
  import layer_1_pixel_sequencer_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        start_i,
  input  logic [NUM_PIXELS-1:0]       image_data_i,
  output logic                        weight_rd_en_o,
  output logic [ADDR_WIDTH-1:0]       weight_addr_o,
  input  logic [NUM_NEURONS*SIZE-1:0] weight_data_i,
  output logic                        acc_clear_o,
  output logic                        load_o,
  output logic                        accumulate_o,
  output logic                        mask_input_o,
  output logic [SIZE-1:0]             vector_input_1_o,
  output logic [SIZE-1:0]             vector_input_2_o,
  output logic [SIZE-1:0]             vector_input_3_o,
  output logic [SIZE-1:0]             vector_input_4_o,
  output logic [SIZE-1:0]             vector_input_5_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam logic [ADDR_WIDTH-1:0]      LastPixel = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [DRAIN_CNT_WIDTH-1:0] LastDrain = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      cnt_q, cnt_d;       // pixel issued in the current STREAM cycle
  logic [DRAIN_CNT_WIDTH-1:0] drain_q, drain_d;
  logic                       rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       acc_clear_q, acc_clear_d;
  logic                       load_q, load_d;
  logic                       mask_q, mask_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       img_load, img_shift, pixel;

  layer_1_pixel_sequencer_image_shift_register u_image (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .load_i  (img_load),
    .shift_i (img_shift),
    .data_i  (image_data_i),
    .pixel_o (pixel)
  );

  // Next-state and next-output logic; every output is computed one cycle ahead
  // so that the ports come straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    acc_clear_d = 1'b0;
    load_d      = 1'b0;
    mask_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    img_load    = 1'b0;
    img_shift   = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start_i) begin
          state_d     = StClear;
          cnt_d       = '0;
          img_load    = 1'b1;
          rd_en_d     = 1'b1;
          addr_d      = '0;
          acc_clear_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      StClear: begin
        // ROM samples address 0 at this edge; pixel 0 issues next cycle.
        state_d   = StStream;
        rd_en_d   = 1'b1;
        addr_d    = ADDR_WIDTH'(1);
        load_d    = 1'b1;
        mask_d    = pixel;
        img_shift = 1'b1;
      end
      StStream: begin
        if (cnt_q == LastPixel) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          cnt_d     = cnt_q + ADDR_WIDTH'(1);
          load_d    = 1'b1;
          mask_d    = pixel;
          img_shift = 1'b1;
          // The last pixel's data is already in flight; no read, address holds.
          if (cnt_q != LastPixel - ADDR_WIDTH'(1)) begin
            rd_en_d = 1'b1;
            addr_d  = cnt_q + ADDR_WIDTH'(2);
          end
        end
      end
      StDrain: begin
        if (drain_q == LastDrain) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DRAIN_CNT_WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      drain_q     <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      acc_clear_q <= 1'b0;
      load_q      <= 1'b0;
      mask_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      acc_clear_q <= acc_clear_d;
      load_q      <= load_d;
      mask_q      <= mask_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign weight_rd_en_o = rd_en_q;
  assign weight_addr_o  = addr_q;
  assign acc_clear_o    = acc_clear_q;
  assign load_o         = load_q;
  assign accumulate_o   = load_q;
  assign mask_input_o   = mask_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

  // ROM data passes straight through, gated so vectors read 0 outside issue cycles.
  assign vector_input_1_o = load_q ? weight_lane(weight_data_i, 0) : '0;
  assign vector_input_2_o = load_q ? weight_lane(weight_data_i, 1) : '0;
  assign vector_input_3_o = load_q ? weight_lane(weight_data_i, 2) : '0;
  assign vector_input_4_o = load_q ? weight_lane(weight_data_i, 3) : '0;
  assign vector_input_5_o = load_q ? weight_lane(weight_data_i, 4) : '0;

endmodule

// File: tb/tb_layer_1_pixel_sequencer.sv
// Self-checking bench for layer_1_pixel_sequencer: table of full-pass scenarios,
// random images/ROMs against an arithmetic reference model, plus reset sequences.
module tb_layer_1_pixel_sequencer;
  import layer_1_pixel_sequencer_pkg::*;

  logic                        clk_i = 1'b0;
  logic                        reset_ni = 1'b0;
  logic                        start_i = 1'b0;
  logic [NUM_PIXELS-1:0]       image_data_i = '0;
  logic                        weight_rd_en_o;
  logic [ADDR_WIDTH-1:0]       weight_addr_o;
  logic [NUM_NEURONS*SIZE-1:0] weight_data_i = '0;
  logic                        acc_clear_o, load_o, accumulate_o, mask_input_o;
  logic [SIZE-1:0]             vector_input_1_o, vector_input_2_o, vector_input_3_o;
  logic [SIZE-1:0]             vector_input_4_o, vector_input_5_o;
  logic                        busy_o, done_o;
  logic [54:0]                 all_outs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_NEURONS*SIZE-1:0] rom [NUM_PIXELS];

  typedef struct {
    string       name;
    int          img_kind;   // 0 ones, 1 checkerboard, 2 sparse, 3 random
    int          rom_kind;   // 0 ramp, 1 distinct lanes, 2 sparse 7F/81, 3 random
    bit          glitch;     // extra start pulses at cycles 10, 100 and DONE
    int          tail;       // cycles observed after the DONE cycle
    bit          use_exp;
    logic [15:0] exp_sum;
  } vec_t;

  vec_t vecs [5];

  layer_1_pixel_sequencer dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .start_i          (start_i),
    .image_data_i     (image_data_i),
    .weight_rd_en_o   (weight_rd_en_o),
    .weight_addr_o    (weight_addr_o),
    .weight_data_i    (weight_data_i),
    .acc_clear_o      (acc_clear_o),
    .load_o           (load_o),
    .accumulate_o     (accumulate_o),
    .mask_input_o     (mask_input_o),
    .vector_input_1_o (vector_input_1_o),
    .vector_input_2_o (vector_input_2_o),
    .vector_input_3_o (vector_input_3_o),
    .vector_input_4_o (vector_input_4_o),
    .vector_input_5_o (vector_input_5_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous weight ROM: data valid the cycle after the read edge.
  always @(posedge clk_i) begin
    if (weight_rd_en_o) weight_data_i <= rom[weight_addr_o];
  end

  assign all_outs = {weight_rd_en_o, weight_addr_o, acc_clear_o, load_o, accumulate_o,
                     mask_input_o, vector_input_1_o, vector_input_2_o, vector_input_3_o,
                     vector_input_4_o, vector_input_5_o, busy_o, done_o};

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_PIXELS-1:0] make_img(input int kind);
    logic [NUM_PIXELS-1:0] img;
    img = '0;
    for (int k = 0; k < NUM_PIXELS; k++) begin
      case (kind)
        0:       img[k] = 1'b1;
        1:       img[k] = 1'(k % 2);
        2:       img[k] = (k == 0) || (k == NUM_PIXELS - 1);
        default: img[k] = 1'($urandom_range(0, 1));
      endcase
    end
    return img;
  endfunction

  task automatic fill_rom(input int kind);
    for (int k = 0; k < NUM_PIXELS; k++) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        case (kind)
          0:       rom[k][n*SIZE +: SIZE] = 8'(k);
          1:       rom[k][n*SIZE +: SIZE] = 8'(k * 7 + n * 51 + 3);
          default: rom[k][n*SIZE +: SIZE] = 8'($urandom);
        endcase
      end
    end
    if (kind == 2) begin
      rom[0]              = {NUM_NEURONS{8'h7F}};
      rom[NUM_PIXELS - 1] = {NUM_NEURONS{8'h81}};
    end
  endtask

  // Reference: each lane sums sign-extended weights of set pixels, scaled by 16.
  function automatic logic [15:0] model_sum(input logic [NUM_PIXELS-1:0] img, input int lane);
    int s;
    s = 0;
    for (int k = 0; k < NUM_PIXELS; k++) begin
      if (img[k]) s += 16 * int'($signed(rom[k][lane*SIZE +: SIZE]));
    end
    return s[15:0];
  endfunction

  task automatic run_pass(input vec_t v);
    logic [NUM_PIXELS-1:0] img;
    logic [15:0]           obs [NUM_NEURONS];
    logic [SIZE-1:0]       vv [NUM_NEURONS];
    logic                  prev_rd;
    logic [ADDR_WIDTH-1:0] prev_addr;
    int loads, clears, dones, reads, clr_t, done_t;
    int bad_mask, bad_vec, bad_lead, bad_busy, bad_acc;
    logic [15:0] exp_s;

    img = make_img(v.img_kind);
    fill_rom(v.rom_kind);
    @(negedge clk_i);
    check({v.name, "_idle_before_start"}, 64'({busy_o, done_o}), 64'(0));
    image_data_i = img;
    start_i      = 1'b1;
    @(posedge clk_i);
    #1;
    start_i      = 1'b0;
    image_data_i = ~img;
    loads = 0; clears = 0; dones = 0; reads = 0; clr_t = -1; done_t = -1;
    bad_mask = 0; bad_vec = 0; bad_lead = 0; bad_busy = 0; bad_acc = 0;
    prev_rd = 1'b0; prev_addr = '0;
    for (int n = 0; n < NUM_NEURONS; n++) obs[n] = '0;

    for (int t = 0; t <= 259 + v.tail; t++) begin
      @(negedge clk_i);
      vv[0] = vector_input_1_o; vv[1] = vector_input_2_o; vv[2] = vector_input_3_o;
      vv[3] = vector_input_4_o; vv[4] = vector_input_5_o;
      if (acc_clear_o) begin
        clears++;
        clr_t = t;
        for (int n = 0; n < NUM_NEURONS; n++) obs[n] = '0;
      end
      if (weight_rd_en_o) reads++;
      if (accumulate_o !== load_o) bad_acc++;
      if (busy_o !== (t <= 259)) bad_busy++;
      if (done_o) begin
        dones++;
        done_t = t;
      end
      if (load_o) begin
        if (loads < NUM_PIXELS) begin
          if (mask_input_o !== img[loads]) bad_mask++;
          for (int n = 0; n < NUM_NEURONS; n++) begin
            if (vv[n] !== rom[loads][n*SIZE +: SIZE]) bad_vec++;
            if (mask_input_o) obs[n] = obs[n] + ({{8{vv[n][7]}}, vv[n]} << 4);
          end
          if (!prev_rd || prev_addr !== ADDR_WIDTH'(loads)) bad_lead++;
        end
        loads++;
      end else begin
        if (mask_input_o !== 1'b0) bad_vec++;
        for (int n = 0; n < NUM_NEURONS; n++) if (vv[n] !== '0) bad_vec++;
      end
      prev_rd   = weight_rd_en_o;
      prev_addr = weight_addr_o;
      start_i   = v.glitch && (t == 10 || t == 100 || t == 259);
    end

    check({v.name, "_clear_count"}, 64'(clears), 64'(1));
    check({v.name, "_clear_cycle"}, 64'(clr_t), 64'(0));
    check({v.name, "_load_count"}, 64'(loads), 64'(NUM_PIXELS));
    check({v.name, "_rom_reads"}, 64'(reads), 64'(NUM_PIXELS));
    check({v.name, "_done_count"}, 64'(dones), 64'(1));
    check({v.name, "_done_cycle"}, 64'(done_t), 64'(NUM_PIXELS + 3));
    check({v.name, "_mask_errs"}, 64'(bad_mask), 64'(0));
    check({v.name, "_vector_errs"}, 64'(bad_vec), 64'(0));
    check({v.name, "_addr_lead_errs"}, 64'(bad_lead), 64'(0));
    check({v.name, "_busy_errs"}, 64'(bad_busy), 64'(0));
    check({v.name, "_acc_errs"}, 64'(bad_acc), 64'(0));
    for (int n = 0; n < NUM_NEURONS; n++) begin
      exp_s = v.use_exp ? v.exp_sum : model_sum(img, n);
      check($sformatf("%s_sum%0d", v.name, n + 1), 64'(obs[n]), 64'(exp_s));
    end
  endtask

  initial begin
    logic [NUM_PIXELS-1:0] img;
    int loads;
    vec_t after_rst;

    vecs[0] = '{"ones_ramp",   0, 0, 1'b1, 0,  1'b1, 16'hF800};
    vecs[1] = '{"b2b_checker", 1, 1, 1'b0, 12, 1'b0, 16'h0000};
    vecs[2] = '{"sparse",      2, 2, 1'b0, 12, 1'b1, 16'h0000};
    vecs[3] = '{"rand_a",      3, 3, 1'b0, 12, 1'b0, 16'h0000};
    vecs[4] = '{"rand_b",      3, 3, 1'b0, 12, 1'b0, 16'h0000};
    after_rst = '{"after_reset", 3, 3, 1'b0, 12, 1'b0, 16'h0000};

    // Reset held with start active and a random image.
    reset_ni     = 1'b0;
    start_i      = 1'b1;
    image_data_i = make_img(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("reset_outputs", 64'(all_outs), 64'(0));
    end
    start_i  = 1'b0;
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("idle_after_release", 64'(all_outs), 64'(0));

    foreach (vecs[i]) run_pass(vecs[i]);

    // Reset in the middle of a pass.
    img = make_img(3);
    fill_rom(3);
    @(negedge clk_i);
    image_data_i = img;
    start_i      = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    loads   = 0;
    for (int t = 0; t < 300 && loads < 100; t++) begin
      @(negedge clk_i);
      if (load_o) loads++;
    end
    check("midpass_reached_pixel100", 64'(loads), 64'(100));
    check("midpass_busy_before_reset", 64'({busy_o, load_o}), 64'(3));
    #2;
    reset_ni = 1'b0;
    #1;
    check("midpass_async_reset_outputs", 64'(all_outs), 64'(0));
    @(negedge clk_i);
    check("midpass_reset_held", 64'(all_outs), 64'(0));
    reset_ni = 1'b1;
    run_pass(after_rst);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
